// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: physical line pointer, cache line and FSM state.
package mem_responder_pkg;
  typedef logic [19:0]  pptr_t;
  typedef logic [127:0] cacheline_t;

  localparam int LINE_OFF_W = 4;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;

  function automatic pptr_t line_align(input pptr_t a);
    return {a[$bits(pptr_t)-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO with occupancy count and a per-entry match vector against a compare value.
module mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [WIDTH-1:0]         cmp,
  output logic [DEPTH-1:0]         match
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [AW-1:0] offs;
    assign offs     = AW'(i) - rptr;
    assign match[i] = ({1'b0, offs} < count) && (mem[i] == cmp);
  end
endmodule

// File: rtl/mem_responder.sv
// Line-granular main-memory model: zero-latency writebacks, in-order reads answered after LATENCY cycles.
// Define MEM_MERGE_EN to fold duplicate outstanding reads into a single response.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY   = 5,
  parameter int QDEPTH    = 4,
  parameter int MEM_LINES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_req_ren,
  input  pptr_t      mem_req_raddr,
  input  logic       mem_req_wen,
  input  pptr_t      mem_req_waddr,
  input  cacheline_t mem_req_wcacheline,
  output logic       mem_rec_en,
  output pptr_t      mem_rec_addr,
  output cacheline_t mem_rec_cacheline,
  output logic       req_full,
  output logic       overflow
);
  localparam int IW = $clog2(MEM_LINES);

  cacheline_t store [MEM_LINES];
  mem_state_t state;
  logic [3:0] cnt;
  pptr_t      cur_addr;

  pptr_t                 ren_line, head;
  logic                  empty, push, pop, merged, ren_ok, accept, fire, start;
  logic [QDEPTH-1:0]     match;
  logic [$clog2(QDEPTH):0] unused_count;
  logic [IW-1:0]         rd_idx, wr_idx;
  cacheline_t            rd_data;
  logic                  unused_bits;

  assign ren_line = line_align(mem_req_raddr);

  mem_req_fifo #(.DEPTH(QDEPTH), .WIDTH($bits(pptr_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ren_line),
    .dout  (head),
    .full  (req_full),
    .empty (empty),
    .count (unused_count),
    .cmp   (ren_line),
    .match (match)
  );

`ifdef MEM_MERGE_EN
  assign merged      = mem_req_ren && ((state == WAIT && cur_addr == ren_line) || (|match));
  assign unused_bits = ^{mem_req_raddr[LINE_OFF_W-1:0], mem_req_waddr, unused_count};
`else
  assign merged      = 1'b0;
  assign unused_bits = ^{mem_req_raddr[LINE_OFF_W-1:0], mem_req_waddr, unused_count, match};
`endif

  assign ren_ok = mem_req_ren && !merged;
  assign accept = ren_ok && !req_full;
  assign fire   = (state == WAIT) && (cnt == '0);
  assign start  = ((state == IDLE) || fire) && (accept || !empty);
  assign pop    = start && !empty;
  // With an empty queue the incoming request goes straight into the timer instead of the FIFO.
  assign push   = accept && !(start && empty);

  assign rd_idx  = cur_addr[LINE_OFF_W +: IW];
  assign wr_idx  = mem_req_waddr[LINE_OFF_W +: IW];
  assign rd_data = (mem_req_wen && wr_idx == rd_idx) ? mem_req_wcacheline : store[rd_idx];

  always_ff @(posedge clk) begin
    if (mem_req_wen) store[wr_idx] <= mem_req_wcacheline;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      cur_addr          <= '0;
      mem_rec_en        <= 1'b0;
      mem_rec_addr      <= '0;
      mem_rec_cacheline <= '0;
      overflow          <= 1'b0;
    end else begin
      mem_rec_en <= fire;
      if (fire) begin
        mem_rec_addr      <= cur_addr;
        mem_rec_cacheline <= rd_data;
      end
      if (ren_ok && req_full) overflow <= 1'b1;
      if (start) begin
        state    <= WAIT;
        cnt      <= 4'(LATENCY - 1);
        cur_addr <= empty ? ren_line : head;
      end else if (fire) begin
        state <= IDLE;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected responses (address, data, edge) queued at issue.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 5;

  typedef struct {
    pptr_t      addr;
    cacheline_t data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req_ren;
  pptr_t      mem_req_raddr;
  logic       mem_req_wen;
  pptr_t      mem_req_waddr;
  cacheline_t mem_req_wcacheline;
  logic       mem_rec_en;
  pptr_t      mem_rec_addr;
  cacheline_t mem_rec_cacheline;
  logic       req_full;
  logic       overflow;

  mem_responder #(.LATENCY(LAT), .QDEPTH(4), .MEM_LINES(4096)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_req_ren        (mem_req_ren),
    .mem_req_raddr      (mem_req_raddr),
    .mem_req_wen        (mem_req_wen),
    .mem_req_waddr      (mem_req_waddr),
    .mem_req_wcacheline (mem_req_wcacheline),
    .mem_rec_en         (mem_rec_en),
    .mem_rec_addr       (mem_rec_addr),
    .mem_rec_cacheline  (mem_rec_cacheline),
    .req_full           (req_full),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         last_resp = -1000;
  exp_t       sb[$];
  cacheline_t model [pptr_t];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rec_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rec_en", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rec_addr", mem_rec_addr, e.addr);
        chk("rec_data", mem_rec_cacheline, e.data);
        chk("rec_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input pptr_t a, input cacheline_t d);
    mem_req_wen = 1'b1;
    mem_req_waddr = a;
    mem_req_wcacheline = d;
    model[line_align(a)] = d;
    @(negedge clk);
    mem_req_wen = 1'b0;
  endtask

  // expect_rsp=0 for requests that must not produce their own response.
  task automatic rd(input pptr_t a, input bit expect_rsp, input bit use_d, input cacheline_t d);
    exp_t e;
    int   issue;
    mem_req_ren = 1'b1;
    mem_req_raddr = a;
    issue = cyc + 1;
    if (expect_rsp) begin
      e.addr = line_align(a);
      e.data = use_d ? d : model[line_align(a)];
      e.cyc  = ((issue > last_resp) ? issue : last_resp) + LAT;
      last_resp = e.cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    mem_req_ren = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    idle(2);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_req_ren = 1'b0;
    mem_req_raddr = '0;
    mem_req_wen = 1'b0;
    mem_req_waddr = '0;
    mem_req_wcacheline = '0;
    idle(3);
    chk("rst_rec_en", mem_rec_en, 0);
    chk("rst_rec_addr", mem_rec_addr, 0);
    chk("rst_rec_data", mem_rec_cacheline, 0);
    chk("rst_full", req_full, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    idle(1);

    // Preload
    wr(20'h00010, {16{8'hA5}});
    for (int k = 1; k <= 6; k++) wr(pptr_t'(k << 8), {4{32'hC0DE0000 + 32'(k)}});

    // Single read with unaligned address
    rd(20'h00013, 1'b1, 1'b0, '0);
    drain();

    // Back-to-back reads; queue never fills
    for (int k = 1; k <= 4; k++) begin
      rd(pptr_t'(k << 8), 1'b1, 1'b0, '0);
      chk("b2b_not_full", req_full, 0);
    end
    drain();

    // Overflow: one bypassed, four queued, sixth dropped
    for (int k = 1; k <= 5; k++) rd(pptr_t'(k << 8), 1'b1, 1'b0, '0);
    chk("ovf_full", req_full, 1);
    chk("ovf_not_yet", overflow, 0);
    rd(20'h00600, 1'b0, 1'b0, '0);
    chk("ovf_set", overflow, 1);
    drain();
    chk("ovf_full_cleared", req_full, 0);
    chk("ovf_sticky", overflow, 1);

    // Write forwarded on the cnt==0 cycle
    wr(20'h00040, 128'hDEAD);
    rd(20'h00040, 1'b1, 1'b1, 128'h1234);
    idle(4);
    wr(20'h00040, 128'h1234);
    drain();

    // Write two cycles after the read lands in the store before the read
    wr(20'h00040, 128'hBEEF);
    rd(20'h00040, 1'b1, 1'b1, 128'h1234);
    idle(1);
    wr(20'h00040, 128'h1234);
    drain();

    // Reset mid-flight discards the read but keeps the store
    rd(20'h00010, 1'b0, 1'b0, '0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    last_resp = -1000;
    chk("midrst_rec_en", mem_rec_en, 0);
    chk("midrst_rec_addr", mem_rec_addr, 0);
    chk("midrst_rec_data", mem_rec_cacheline, 0);
    chk("midrst_full", req_full, 0);
    chk("midrst_overflow", overflow, 0);
    idle(10);
    rd(20'h00010, 1'b1, 1'b0, '0);
    drain();

    // Duplicate reads
    wr(20'h00080, 128'h0808_0808);
    rd(20'h00080, 1'b1, 1'b0, '0);
`ifdef MEM_MERGE_EN
    rd(20'h00080, 1'b0, 1'b0, '0);
`else
    rd(20'h00080, 1'b1, 1'b0, '0);
`endif
    drain();
    idle(LAT + 3);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
